// File: rtl/rtz_mac_ctrl_if.sv
// rtl/rtz_mac_ctrl_if.sv - job, operand and result signals of the rounding MAC controller
interface rtz_mac_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8,
    parameter int SH_W   = 4
);
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic [SH_W-1:0]          rnd_sh;
    logic                     abort;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] b_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  result;
    logic                     sat_flag;
    logic                     busy;

    modport master (
        output start, len, rnd_sh, abort, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, result, sat_flag, busy
    );

    modport slave (
        input  start, len, rnd_sh, abort, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, result, sat_flag, busy
    );
endinterface

// File: rtl/rtz_mac_ctrl.sv
// rtl/rtz_mac_ctrl.sv - saturating dot-product sequencer with round-toward-zero result
module rtz_mac_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8,
    parameter int SH_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    rtz_mac_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, DONE} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]         count;
    logic [LEN_W-1:0]         len_q;
    logic [SH_W-1:0]          sh_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic signed [ACC_W-1:0]  result_q;
    logic                     sat_q;
    logic                     busy_q;

    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W:0]             sum;
    logic                       sum_ovf;
    logic signed [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]           keep_mask;
    logic [ACC_W-1:0]           lsb_unit;
    logic [ACC_W-1:0]           cleared;
    logic signed [ACC_W-1:0]    rtz_val;
    logic                       last_pair;

    assign prod = bus.a_in * bus.b_in;

    // One guard bit is enough: a product never exceeds a quarter of the accumulator range.
    assign sum      = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_next = sum_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

    assign last_pair = (LEN_W'(count + 1'b1) == len_q);

    always_comb begin
        keep_mask = '1 << sh_q;
        lsb_unit  = {{(ACC_W-1){1'b0}}, 1'b1} << sh_q;
        cleared   = acc & keep_mask;
        rtz_val   = cleared;
        if (int'(sh_q) >= ACC_W-1) begin
            rtz_val = (acc == ACC_MIN) ? ACC_MIN : '0;
        end else if (acc[ACC_W-1] && ((acc & ~keep_mask) != '0)) begin
            // Negative values truncate upward so the magnitude shrinks.
            rtz_val = cleared + lsb_unit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            len_q       <= '0;
            sh_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q  <= bus.len;
                        sh_q   <= bus.rnd_sh;
                        acc    <= '0;
                        count  <= '0;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.len == '0) begin
                            state <= ROUND;
                        end else begin
                            state      <= ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (bus.in_valid && in_ready_q) begin
                        acc   <= acc_next;
                        count <= LEN_W'(count + 1'b1);
                        if (sum_ovf) begin
                            sat_q <= 1'b1;
                        end
                        if (last_pair) begin
                            state      <= ROUND;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ROUND: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        result_q    <= rtz_val;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.abort || bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.sat_flag  = sat_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/rtz_mac_ctrl.md
Name: rtz_mac_ctrl

Overview:
- Sequences one dot-product job through a shared signed multiply-accumulate datapath.
- Streams operand pairs in under a valid/ready handshake and accumulates with saturation.
- Applies round-toward-zero to the sum at a programmable bit position and returns the result under a valid/ready handshake.
- Sits between the operand feeder and the error-compensation MAC output path of the low-voltage DNN accelerator.

Parameters:
- DATA_W, 8, signed operand width of a_in/b_in.
- ACC_W, 24, signed accumulator and result width; must be ≥ 2*DATA_W.
- LEN_W, 8, width of the job length field (max LEN_W-bit count of pairs).
- SH_W, 4, width of the rounding-position field.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  job request; accepted only in IDLE.
- len  input  LEN_W  number of operand pairs; latched on accepted start.
- rnd_sh  input  SH_W  number of LSBs cleared by rounding; latched on accepted start.
- abort  input  1  synchronous job cancel.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller accepts a pair.
- a_in  input  DATA_W  signed operand A.
- b_in  input  DATA_W  signed operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  ACC_W  rounded signed result.
- sat_flag  output  1  accumulator saturated during this job.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, count=0; in_ready=0, out_valid=0, result=0, sat_flag=0, busy=0.
- States:
  - IDLE: start=1 latches len and rnd_sh, clears acc, count and sat_flag. Goes to ACCUM, or to ROUND if len=0.
  - ACCUM: in_ready=1. Each cycle with in_valid & in_ready: acc <= sat(acc + a_in*b_in), count++. The product is the full 2*DATA_W signed product, sign-extended. When the pair that makes count==len is accepted, go to ROUND; in_ready drops the next cycle.
  - ROUND: one cycle, in_ready=0. Loads result <= rtz(acc, sh) and goes to DONE.
  - DONE: out_valid=1; result and sat_flag held stable. out_valid & out_ready returns to IDLE; out_valid=0 the next cycle.
- Saturation: if the true sum exceeds +(2^(ACC_W-1)-1) or is below -2^(ACC_W-1), clamp to that bound and set sat_flag. sat_flag is sticky until the next accepted start.
- rtz(x, sh):
  - Clear the low sh bits of x, rounding the magnitude toward zero.
  - x ≥ 0: x with bits [sh-1:0] cleared.
  - x < 0: (x with bits [sh-1:0] cleared) + 2^sh when any cleared bit is 1; otherwise x unchanged.
  - sh=0 gives x.
  - sh ≥ ACC_W-1 gives 0 for every x except the most-negative value, which is returned unchanged.
- Latency: len=N with in_valid held high gives out_valid in cycle N+2 after start (N ACCUM cycles + ROUND + DONE entry). len=0 gives out_valid 2 cycles after start.
- start in a non-IDLE state is ignored, with no effect on the running job.
- abort in ACCUM, ROUND or DONE returns to IDLE next cycle: out_valid=0, no result handshake. abort in IDLE is ignored. When abort and start are both high in IDLE, start wins.
- in_valid is ignored outside ACCUM. out_ready is ignored outside DONE.
- rst asserted mid-job clears immediately regardless of clk; the partial sum is discarded.

Test Plan:
- Positive rounding, rnd_sh=2, len=2: pairs (3,5),(-2,4) → sum 7, result=4, sat_flag=0; out_valid 4 cycles after start.
- Negative rounding, rnd_sh=2, len=2: pairs (-3,5),(2,4) → sum -7, result=-4. Repeat with sum -8 → result=-8. Repeat with sum -1, rnd_sh=3 → result=0.
- Saturation, ACC_W=16, rnd_sh=0, len=3: pairs (127,127)×3 → result=32767, sat_flag=1. A next job with len=1, pair (1,1) → result=1, sat_flag=0.
- Handshake stress:
  - in_valid toggled 1,0,1,0 with len=2 → accumulation counts only accepted pairs.
  - out_ready held low 5 cycles → result stable, out_valid high; start pulses during this window are ignored.
  - len=0 → result=0 two cycles after start.
- Abort and reset:
  - abort after 1 of 3 pairs → IDLE next cycle, no out_valid.
  - Next job (len=1, (2,3), rnd_sh=1) → result=6.
  - rst pulsed asynchronously mid-ACCUM → all outputs 0 before the next clk edge.
